// File: rtl/ifetch_unit.sv
// Instruction fetch unit: request generator, 2-entry instruction buffer and redirect/drop handling.
// Optional FETCH_MISALIGN_EN: a redirect target with bit[1] set traps to TRAP_PC and pulses fetch_misalign.
module ifetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] TRAP_PC  = 32'h0000_0100
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [31:0] imem_addr,
  input  logic        imem_rsp_valid,
  input  logic [31:0] imem_rsp_data,
  input  logic [1:0]  pcsrc,
  input  logic [31:0] pc_target,
  input  logic [31:0] alu_result,
  output logic        instr_valid,
  input  logic        instr_ready,
  output logic [31:0] instr,
  output logic [31:0] instr_pc,
  output logic [6:0]  op,
  output logic [2:0]  func3,
  output logic        func7b5,
  output logic        fetch_misalign
);

  localparam logic [31:0] NOP = 32'h0000_0013;

  typedef enum logic {BOOT, RUN} state_t;

  state_t      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] resp_pc_q, resp_pc_d;
  logic [1:0]  out_q, out_d;
  logic [1:0]  drop_q, drop_d;
  logic [1:0]  cnt_q, cnt_d;
  logic        wr_ptr_q, wr_ptr_d;
  logic        rd_ptr_q, rd_ptr_d;
  logic [31:0] buf_instr_q [2];
  logic [31:0] buf_pc_q [2];

  logic        redirect, accept, push, pop;
  logic [2:0]  inflight;
  logic [31:0] raw_tgt, redir_pc;

  assign redirect    = (pcsrc != 2'b00);
  assign inflight    = {1'b0, out_q} + {1'b0, cnt_q};
  assign accept      = imem_req_valid & imem_req_ready;
  assign push        = imem_rsp_valid & ~redirect & (drop_q == 2'd0);
  assign pop         = instr_valid & instr_ready & ~redirect;
  assign imem_addr   = pc_q;
  assign instr_valid = (cnt_q != 2'd0);
  assign instr       = buf_instr_q[rd_ptr_q];
  assign instr_pc    = buf_pc_q[rd_ptr_q];
  assign op          = instr[6:0];
  assign func3       = instr[14:12];
  assign func7b5     = instr[30];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= BOOT;
    else        state_q <= state_d;
  end

  // Requests are throttled so outstanding + buffered never exceeds the buffer depth.
  always_comb begin
    state_d        = state_q;
    imem_req_valid = 1'b0;
    case (state_q)
      BOOT:    state_d = RUN;
      RUN:     imem_req_valid = (inflight < 3'd2) && !redirect;
      default: state_d = BOOT;
    endcase
  end

  always_comb begin
    raw_tgt = TRAP_PC;
    case (pcsrc)
      2'b01:   raw_tgt = pc_target;
      2'b10:   raw_tgt = alu_result & ~32'h1;
      default: raw_tgt = TRAP_PC;
    endcase
  end

`ifdef FETCH_MISALIGN_EN
  logic mis_hit;
  logic mis_q;

  assign mis_hit  = redirect & raw_tgt[1];
  assign redir_pc = mis_hit ? TRAP_PC : (raw_tgt & ~32'h3);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) mis_q <= 1'b0;
    else        mis_q <= mis_hit;
  end

  assign fetch_misalign = mis_q;
`else
  assign redir_pc       = raw_tgt & ~32'h3;
  assign fetch_misalign = 1'b0;
`endif

  always_comb begin
    pc_d      = pc_q;
    out_d     = out_q;
    drop_d    = drop_q;
    cnt_d     = cnt_q;
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    resp_pc_d = resp_pc_q;

    if (redirect)    pc_d = redir_pc;
    else if (accept) pc_d = pc_q + 32'd4;

    case ({accept, imem_rsp_valid})
      2'b10:   out_d = out_q + 2'd1;
      2'b01:   out_d = out_q - 2'd1;
      default: out_d = out_q;
    endcase

    // Requests still in flight after this cycle's response belong to the abandoned path.
    if (redirect)                            drop_d = out_q - {1'b0, imem_rsp_valid};
    else if (imem_rsp_valid && drop_q != 0)  drop_d = drop_q - 2'd1;

    if (push) begin
      wr_ptr_d  = ~wr_ptr_q;
      resp_pc_d = resp_pc_q + 32'd4;
    end
    if (pop) rd_ptr_d = ~rd_ptr_q;

    case ({push, pop})
      2'b10:   cnt_d = cnt_q + 2'd1;
      2'b01:   cnt_d = cnt_q - 2'd1;
      default: cnt_d = cnt_q;
    endcase

    // Flush realigns the read pointer so the next push is the next entry read.
    if (redirect) begin
      cnt_d     = 2'd0;
      rd_ptr_d  = wr_ptr_q;
      resp_pc_d = redir_pc;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q      <= RESET_PC;
      resp_pc_q <= RESET_PC;
      out_q     <= 2'd0;
      drop_q    <= 2'd0;
      cnt_q     <= 2'd0;
      wr_ptr_q  <= 1'b0;
      rd_ptr_q  <= 1'b0;
    end else begin
      pc_q      <= pc_d;
      resp_pc_q <= resp_pc_d;
      out_q     <= out_d;
      drop_q    <= drop_d;
      cnt_q     <= cnt_d;
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 2; i++) begin
        buf_instr_q[i] <= NOP;
        buf_pc_q[i]    <= 32'h0;
      end
    end else if (push) begin
      buf_instr_q[wr_ptr_q] <= imem_rsp_data;
      buf_pc_q[wr_ptr_q]    <= resp_pc_q;
    end
  end

endmodule

// File: doc/ifetch_unit.md
IFETCH_UNIT -- requirements
Module: ifetch_unit

Interface
REQ-001 The block SHALL have parameter RESET_PC, default 32'h0000_0000, giving the first fetch address after reset.
REQ-002 The block SHALL have parameter TRAP_PC, default 32'h0000_0100, giving the redirect target for pcsrc=2'b11.
REQ-003 clk  input  1  sole clock; all state updates on rising edge.
REQ-004 rst_n  input  1  asynchronous active-low reset.
REQ-005 imem_req_valid  output  1  fetch request valid.
REQ-006 imem_req_ready  input  1  memory accepts request this cycle.
REQ-007 imem_addr  output  32  word-aligned fetch address.
REQ-008 imem_rsp_valid  input  1  instruction word returned, in request order.
REQ-009 imem_rsp_data  input  32  returned instruction word.
REQ-010 pcsrc  input  2  00 sequential, 01 branch/jal target, 10 jalr target, 11 trap.
REQ-011 pc_target  input  32  branch/jal target address.
REQ-012 alu_result  input  32  jalr target address.
REQ-013 instr_valid  output  1  instruction buffer non-empty.
REQ-014 instr_ready  input  1  decode stage accepts instruction.
REQ-015 instr  output  32  buffered instruction word.
REQ-016 instr_pc  output  32  address of instr.
REQ-017 op / func3 / func7b5  output  7 / 3 / 1  instr[6:0], instr[14:12], instr[30], driven to the controller.
REQ-018 fetch_misalign  output  1  misaligned redirect flag (see Configuration).

Function
REQ-019 FSM SHALL have two states. BOOT (one cycle after reset release, no request) -> RUN unconditionally.
REQ-020 In RUN, imem_req_valid SHALL be 1 when (outstanding + buffer count) < 2 and no redirect is active this cycle.
REQ-021 A request SHALL be accepted when imem_req_valid & imem_req_ready; fetch PC then advances by 4 next cycle, 32-bit wrap-around.
REQ-022 imem_addr and imem_req_valid SHALL stay stable while imem_req_ready=0.
REQ-023 The outstanding counter (0..2) SHALL increment on accept, decrement on imem_rsp_valid, and hold on both together.
REQ-024 The instruction buffer SHALL be a 2-entry FIFO of {instr, pc}, written the cycle after imem_rsp_valid; it never overflows by REQ-020.
REQ-025 instr_valid SHALL equal buffer not-empty; an entry SHALL pop on instr_valid & instr_ready; push and pop in one cycle SHALL keep the count.
REQ-026 A redirect SHALL occur when pcsrc != 2'b00. Next fetch PC: pc_target (01), alu_result & ~32'h1 (10), TRAP_PC (11).
REQ-027 On redirect, the buffer SHALL clear and no request SHALL issue that cycle; redirect wins over a same-cycle pop.
REQ-028 On redirect, drop_cnt SHALL load the number of requests still unanswered after this cycle's response. Every such later response SHALL decrement drop_cnt and SHALL NOT be buffered.
REQ-029 A response arriving in the redirect cycle SHALL be discarded.
REQ-030 Requests MAY issue while drop_cnt > 0. Responses are buffered only when drop_cnt = 0.
REQ-031 Latency SHALL be 1 cycle from imem_rsp_valid to instr_valid with an empty buffer.

Reset
REQ-032 On rst_n=0, asynchronously: state=BOOT, fetch PC=RESET_PC, outstanding=0, drop_cnt=0, buffer empty, imem_req_valid=0, instr_valid=0, instr=32'h0000_0013 (nop), instr_pc=0, fetch_misalign=0.
REQ-033 Reset mid-transaction SHALL abandon all outstanding requests. The memory side is reset by the same rst_n.

Configuration
REQ-034 With FETCH_MISALIGN_EN defined: a redirect target with bit[1] set SHALL raise fetch_misalign for one cycle, the PC SHALL load TRAP_PC, and the target SHALL NOT be fetched.
REQ-035 Without FETCH_MISALIGN_EN: fetch_misalign SHALL be tied 0, and target bits[1:0] SHALL be forced to 00.

Verification
REQ-036 Reset release, ready=1, memory 1-cycle latency -> first request at RESET_PC on cycle 2, instr_valid at cycle 4, then addresses 0x0, 0x4, 0x8 in order.
REQ-037 instr_ready=0 for 5 cycles -> buffer fills to 2, imem_req_valid drops, no response lost; resume -> pcs 0x0, 0x4, 0x8 consecutive.
REQ-038 pcsrc=01, pc_target=0x200 with 2 outstanding -> both stale responses dropped, next instr_pc=0x200.
REQ-039 pcsrc=10, alu_result=0x301 -> next fetch at 0x300. pcsrc=11 -> fetch at 0x100.
REQ-040 FETCH_MISALIGN_EN defined, pc_target=0x202 -> fetch_misalign pulse for 1 cycle, next fetch at 0x100.
REQ-041 rst_n asserted with 2 outstanding and a full buffer -> all outputs at reset values immediately; refetch starts at RESET_PC.
